// File: rtl/mcu_obi_mem_arbiter.sv
// ============================================================================
// Module      : mcu_obi_mem_arbiter
// Description : N-master to 1-slave req/gnt/rvalid arbiter with request lock,
//               in-order response routing and protocol-error reporting.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mcu_obi_mem_arbiter #(
  parameter int N_MASTERS       = 2,
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 32,
  parameter int MAX_OUTSTANDING = 2,
  parameter int RR_EN           = 1,
  localparam int BE_W           = DATA_W / 8,
  localparam int CNT_W          = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [N_MASTERS-1:0]          m_req_i,
  output logic [N_MASTERS-1:0]          m_gnt_o,
  input  logic [N_MASTERS-1:0]          m_we_i,
  input  logic [N_MASTERS*BE_W-1:0]     m_be_i,
  input  logic [N_MASTERS*ADDR_W-1:0]   m_addr_i,
  input  logic [N_MASTERS*DATA_W-1:0]   m_wdata_i,
  output logic [N_MASTERS-1:0]          m_rvalid_o,
  output logic [N_MASTERS*DATA_W-1:0]   m_rdata_o,
  output logic [N_MASTERS-1:0]          m_err_o,
  output logic                          s_req_o,
  input  logic                          s_gnt_i,
  output logic                          s_we_o,
  output logic [BE_W-1:0]               s_be_o,
  output logic [ADDR_W-1:0]             s_addr_o,
  output logic [DATA_W-1:0]             s_wdata_o,
  input  logic                          s_rvalid_i,
  input  logic [DATA_W-1:0]             s_rdata_i,
  input  logic                          s_err_i,
  output logic [CNT_W-1:0]              outstanding_o,
  output logic                          unexp_rvalid_o
);

  localparam int ID_W  = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
  localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

  logic [ID_W-1:0]  fifo_q [MAX_OUTSTANDING];
  logic [ID_W-1:0]  fifo_d [MAX_OUTSTANDING];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d, lock_idx_q, lock_idx_d;
  logic             lock_q, lock_d, unexp_q, unexp_d;

  logic [ID_W-1:0]  sel, head;
  logic             full, empty, lock_vld, s_req, accept, pop, found;
  int               idx_v;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full     = (cnt_q == CNT_W'(MAX_OUTSTANDING));
  assign empty    = (cnt_q == '0);
  assign lock_vld = lock_q & m_req_i[lock_idx_q];
  // No path from s_rvalid_i: a pop frees a slot only from the next cycle on.
  assign s_req    = rst_ni & (|m_req_i) & ~full;
  assign accept   = s_req & s_gnt_i;
  assign pop      = rst_ni & s_rvalid_i & ~empty;
  assign head     = fifo_q[rd_ptr_q];

  always_comb begin
    sel   = '0;
    found = 1'b0;
    idx_v = 0;
    if (lock_vld) begin
      sel = lock_idx_q;
    end else if (RR_EN != 0) begin
      for (int k = 0; k < N_MASTERS; k++) begin
        idx_v = (int'(rr_ptr_q) + k) % N_MASTERS;
        if (!found && m_req_i[idx_v]) begin
          sel   = ID_W'(idx_v);
          found = 1'b1;
        end
      end
    end else begin
      for (int k = N_MASTERS - 1; k >= 0; k--) begin
        if (m_req_i[k]) sel = ID_W'(k);
      end
    end
  end

  always_comb begin
    fifo_d     = fifo_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    cnt_d      = cnt_q;
    rr_ptr_d   = rr_ptr_q;
    lock_d     = lock_q;
    lock_idx_d = lock_idx_q;
    unexp_d    = unexp_q | (s_rvalid_i & empty);
    if (accept) begin
      fifo_d[wr_ptr_q] = sel;
      wr_ptr_d         = ptr_inc(wr_ptr_q);
      rr_ptr_d         = (sel == ID_W'(N_MASTERS - 1)) ? '0 : sel + ID_W'(1);
      lock_d           = 1'b0;
    end else if (s_req && !s_gnt_i) begin
      lock_d     = 1'b1;
      lock_idx_d = sel;
    end else if (lock_q && !m_req_i[lock_idx_q]) begin
      lock_d = 1'b0;
    end
    if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
    if (accept && !pop)      cnt_d = cnt_q + CNT_W'(1);
    else if (!accept && pop) cnt_d = cnt_q - CNT_W'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < MAX_OUTSTANDING; i++) fifo_q[i] <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      rr_ptr_q   <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
      unexp_q    <= 1'b0;
    end else begin
      fifo_q     <= fifo_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      rr_ptr_q   <= rr_ptr_d;
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
      unexp_q    <= unexp_d;
    end
  end

  always_comb begin
    m_gnt_o    = '0;
    m_rvalid_o = '0;
    m_err_o    = '0;
    if (accept) m_gnt_o[sel] = 1'b1;
    if (pop) begin
      m_rvalid_o[head] = 1'b1;
      m_err_o[head]    = s_err_i;
    end
  end

  assign s_req_o        = s_req;
  assign s_we_o         = rst_ni & m_we_i[sel];
  assign s_be_o         = rst_ni ? m_be_i[int'(sel)*BE_W +: BE_W] : '0;
  assign s_addr_o       = rst_ni ? m_addr_i[int'(sel)*ADDR_W +: ADDR_W] : '0;
  assign s_wdata_o      = rst_ni ? m_wdata_i[int'(sel)*DATA_W +: DATA_W] : '0;
  assign m_rdata_o      = rst_ni ? {N_MASTERS{s_rdata_i}} : '0;
  assign outstanding_o  = cnt_q;
  assign unexp_rvalid_o = unexp_q;

endmodule

`default_nettype wire

// File: tb/tb_mcu_obi_mem_arbiter.sv
// ============================================================================
// Module      : tb_mcu_obi_mem_arbiter
// Description : Directed bench for mcu_obi_mem_arbiter (round-robin and fixed).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mcu_obi_mem_arbiter;

  localparam int N  = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = 4;
  localparam int MO = 2;
  localparam int CW = 2;

  logic            clk_i = 1'b0;
  logic            rst_ni = 1'b0;
  logic [N-1:0]    m_req_i = '0;
  logic [N-1:0]    m_we_i = 3'b010;
  logic [N*BW-1:0] m_be_i = 12'hF31;
  logic [N*AW-1:0] m_addr_i = {32'h0000_3000, 32'h0000_2000, 32'h0000_1000};
  logic [N*DW-1:0] m_wdata_i = {32'h0000_00A2, 32'h0000_00A1, 32'h0000_00A0};
  logic            s_gnt_i = 1'b0;
  logic            s_rvalid_i = 1'b0;
  logic [DW-1:0]   s_rdata_i = '0;
  logic            s_err_i = 1'b0;

  logic [N-1:0]    rr_gnt, rr_rv, rr_err, fp_gnt, fp_rv, fp_err;
  logic [N*DW-1:0] rr_rdata, fp_rdata;
  logic            rr_req, rr_we, fp_req, fp_we, rr_unexp, fp_unexp;
  logic [BW-1:0]   rr_be, fp_be;
  logic [AW-1:0]   rr_addr, fp_addr;
  logic [DW-1:0]   rr_wdata, fp_wdata;
  logic [CW-1:0]   rr_out, fp_out;

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [2:0] EXP_G  [4] = '{3'b010, 3'b100, 3'b001, 3'b010};
  localparam logic [2:0] EXP_RV [4] = '{3'b001, 3'b010, 3'b100, 3'b001};

  always #5 clk_i = ~clk_i;

  mcu_obi_mem_arbiter #(.N_MASTERS(N), .ADDR_W(AW), .DATA_W(DW),
                        .MAX_OUTSTANDING(MO), .RR_EN(1)) u_rr (
    .clk_i(clk_i), .rst_ni(rst_ni), .m_req_i(m_req_i), .m_gnt_o(rr_gnt),
    .m_we_i(m_we_i), .m_be_i(m_be_i), .m_addr_i(m_addr_i), .m_wdata_i(m_wdata_i),
    .m_rvalid_o(rr_rv), .m_rdata_o(rr_rdata), .m_err_o(rr_err),
    .s_req_o(rr_req), .s_gnt_i(s_gnt_i), .s_we_o(rr_we), .s_be_o(rr_be),
    .s_addr_o(rr_addr), .s_wdata_o(rr_wdata), .s_rvalid_i(s_rvalid_i),
    .s_rdata_i(s_rdata_i), .s_err_i(s_err_i), .outstanding_o(rr_out),
    .unexp_rvalid_o(rr_unexp)
  );

  mcu_obi_mem_arbiter #(.N_MASTERS(N), .ADDR_W(AW), .DATA_W(DW),
                        .MAX_OUTSTANDING(MO), .RR_EN(0)) u_fp (
    .clk_i(clk_i), .rst_ni(rst_ni), .m_req_i(m_req_i), .m_gnt_o(fp_gnt),
    .m_we_i(m_we_i), .m_be_i(m_be_i), .m_addr_i(m_addr_i), .m_wdata_i(m_wdata_i),
    .m_rvalid_o(fp_rv), .m_rdata_o(fp_rdata), .m_err_o(fp_err),
    .s_req_o(fp_req), .s_gnt_i(s_gnt_i), .s_we_o(fp_we), .s_be_o(fp_be),
    .s_addr_o(fp_addr), .s_wdata_o(fp_wdata), .s_rvalid_i(s_rvalid_i),
    .s_rdata_i(s_rdata_i), .s_err_i(s_err_i), .outstanding_o(fp_out),
    .unexp_rvalid_o(fp_unexp)
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic drive(input logic [2:0] req, input logic gnt, input logic rv,
                       input logic err, input logic [31:0] rd);
    m_req_i    = req;
    s_gnt_i    = gnt;
    s_rvalid_i = rv;
    s_err_i    = err;
    s_rdata_i  = rd;
    #1;
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    drive(3'b000, 1'b0, 1'b0, 1'b0, 32'h0);
    rst_ni = 1'b0;
    #2;
    rst_ni = 1'b1;
    step();
  endtask

  initial begin
    // Outputs must be forced low while in reset, whatever the inputs do
    drive(3'b111, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFFF);
    check("rst_s_req", 64'(rr_req), 64'h0);
    check("rst_gnt", 64'(rr_gnt), 64'h0);
    check("rst_rvalid", 64'(rr_rv), 64'h0);
    check("rst_err", 64'(rr_err), 64'h0);
    check("rst_rdata", 64'(rr_rdata[31:0]), 64'h0);
    check("rst_addr", 64'(rr_addr), 64'h0);
    check("rst_out", 64'(rr_out), 64'h0);
    check("rst_unexp", 64'(rr_unexp), 64'h0);
    drive(3'b000, 1'b0, 1'b0, 1'b0, 32'h0);
    rst_ni = 1'b1;
    step();

    // Single read from master 0
    drive(3'b001, 1'b1, 1'b0, 1'b0, 32'h0);
    check("t1_gnt", 64'(rr_gnt), 64'h1);
    check("t1_s_req", 64'(rr_req), 64'h1);
    check("t1_addr", 64'(rr_addr), 64'h1000);
    check("t1_out0", 64'(rr_out), 64'h0);
    step();
    drive(3'b000, 1'b0, 1'b1, 1'b0, 32'hDEAD_BEEF);
    check("t1_out1", 64'(rr_out), 64'h1);
    check("t1_rvalid", 64'(rr_rv), 64'h1);
    check("t1_rdata_lo", 64'(rr_rdata[31:0]), 64'hDEAD_BEEF);
    check("t1_rdata_hi", 64'(rr_rdata[95:64]), 64'hDEAD_BEEF);
    step();
    drive(3'b000, 1'b0, 1'b0, 1'b0, 32'h0);
    check("t1_out_end", 64'(rr_out), 64'h0);
    check("t1_unexp", 64'(rr_unexp), 64'h0);

    // All masters requesting continuously: RR rotates, fixed priority sticks at 0
    do_reset();
    drive(3'b111, 1'b1, 1'b0, 1'b0, 32'h0);
    check("rr_gnt_c0", 64'(rr_gnt), 64'h1);
    check("fp_gnt_c0", 64'(fp_gnt), 64'h1);
    step();
    for (int i = 0; i < 4; i++) begin
      drive(3'b111, 1'b1, 1'b1, 1'b0, 32'h1234_0000 + 32'(i));
      check($sformatf("rr_gnt_c%0d", i + 1), 64'(rr_gnt), 64'(EXP_G[i]));
      check($sformatf("rr_rv_c%0d", i + 1), 64'(rr_rv), 64'(EXP_RV[i]));
      check($sformatf("fp_gnt_c%0d", i + 1), 64'(fp_gnt), 64'h1);
      check($sformatf("fp_rv_c%0d", i + 1), 64'(fp_rv), 64'h1);
      check($sformatf("rr_out_c%0d", i + 1), 64'(rr_out), 64'h1);
      step();
    end
    drive(3'b000, 1'b0, 1'b1, 1'b0, 32'h0);
    check("rr_rv_drain", 64'(rr_rv), 64'h2);
    step();
    drive(3'b000, 1'b0, 1'b0, 1'b0, 32'h0);
    check("rr_out_drain", 64'(rr_out), 64'h0);

    // Lock: master 1 waits for gnt while master 0 joins in
    do_reset();
    drive(3'b010, 1'b0, 1'b0, 1'b0, 32'h0);
    check("lk_s_req", 64'(rr_req), 64'h1);
    check("lk_addr0", 64'(rr_addr), 64'h2000);
    check("lk_gnt0", 64'(rr_gnt), 64'h0);
    step();
    for (int i = 0; i < 2; i++) begin
      drive(3'b011, 1'b0, 1'b0, 1'b0, 32'h0);
      check($sformatf("lk_rr_addr%0d", i + 1), 64'(rr_addr), 64'h2000);
      check($sformatf("lk_fp_addr%0d", i + 1), 64'(fp_addr), 64'h2000);
      step();
    end
    drive(3'b011, 1'b1, 1'b0, 1'b0, 32'h0);
    check("lk_rr_gnt", 64'(rr_gnt), 64'h2);
    check("lk_fp_gnt", 64'(fp_gnt), 64'h2);
    check("lk_we", 64'(rr_we), 64'h1);
    check("lk_be", 64'(rr_be), 64'h3);
    check("lk_wdata", 64'(rr_wdata), 64'hA1);
    step();
    drive(3'b001, 1'b1, 1'b0, 1'b0, 32'h0);
    check("lk_gnt_m0", 64'(rr_gnt), 64'h1);
    step();
    drive(3'b000, 1'b0, 1'b1, 1'b0, 32'h11);
    check("lk_rv1", 64'(rr_rv), 64'h2);
    step();
    drive(3'b000, 1'b0, 1'b1, 1'b0, 32'h22);
    check("lk_rv2", 64'(rr_rv), 64'h1);
    step();
    drive(3'b000, 1'b0, 1'b0, 1'b0, 32'h0);
    check("lk_out_end", 64'(rr_out), 64'h0);

    // Outstanding limit
    do_reset();
    drive(3'b001, 1'b1, 1'b0, 1'b0, 32'h0);
    check("fl_req0", 64'(rr_req), 64'h1);
    step();
    drive(3'b001, 1'b1, 1'b0, 1'b0, 32'h0);
    check("fl_out1", 64'(rr_out), 64'h1);
    check("fl_req1", 64'(rr_req), 64'h1);
    step();
    drive(3'b001, 1'b1, 1'b0, 1'b0, 32'h0);
    check("fl_out2", 64'(rr_out), 64'h2);
    check("fl_req_full", 64'(rr_req), 64'h0);
    check("fl_gnt_full", 64'(rr_gnt), 64'h0);
    step();
    drive(3'b001, 1'b1, 1'b1, 1'b0, 32'h55);
    check("fl_req_pop", 64'(rr_req), 64'h0);
    check("fl_rv_pop", 64'(rr_rv), 64'h1);
    step();
    drive(3'b001, 1'b1, 1'b0, 1'b0, 32'h0);
    check("fl_out_after", 64'(rr_out), 64'h1);
    check("fl_req_after", 64'(rr_req), 64'h1);
    check("fl_gnt_after", 64'(rr_gnt), 64'h1);
    step();
    drive(3'b000, 1'b0, 1'b1, 1'b0, 32'h0);
    step();
    drive(3'b000, 1'b0, 1'b1, 1'b0, 32'h0);
    step();
    drive(3'b000, 1'b0, 1'b0, 1'b0, 32'h0);
    check("fl_out_end", 64'(rr_out), 64'h0);

    // Response ordering and error routing: accepts m1, m0, m1
    do_reset();
    drive(3'b010, 1'b1, 1'b0, 1'b0, 32'h0);
    step();
    drive(3'b001, 1'b1, 1'b0, 1'b0, 32'h0);
    step();
    drive(3'b000, 1'b0, 1'b1, 1'b0, 32'h0000_000A);
    check("or_out2", 64'(rr_out), 64'h2);
    check("or_rv0", 64'(rr_rv), 64'h2);
    check("or_err0", 64'(rr_err), 64'h0);
    check("or_rdata0", 64'(rr_rdata[63:32]), 64'hA);
    step();
    drive(3'b010, 1'b1, 1'b1, 1'b1, 32'h0000_000B);
    check("or_rv1", 64'(rr_rv), 64'h1);
    check("or_err1", 64'(rr_err), 64'h1);
    check("or_gnt1", 64'(rr_gnt), 64'h2);
    step();
    drive(3'b000, 1'b0, 1'b1, 1'b0, 32'h0000_000C);
    check("or_rv2", 64'(rr_rv), 64'h2);
    check("or_err2", 64'(rr_err), 64'h0);
    step();
    drive(3'b000, 1'b0, 1'b0, 1'b0, 32'h0);
    check("or_out_end", 64'(rr_out), 64'h0);

    // Stray response with nothing outstanding
    drive(3'b000, 1'b0, 1'b1, 1'b1, 32'h77);
    check("ux_rv", 64'(rr_rv), 64'h0);
    check("ux_err", 64'(rr_err), 64'h0);
    check("ux_pre", 64'(rr_unexp), 64'h0);
    step();
    drive(3'b000, 1'b0, 1'b0, 1'b0, 32'h0);
    check("ux_set", 64'(rr_unexp), 64'h1);
    step();
    check("ux_sticky", 64'(rr_unexp), 64'h1);
    check("ux_out", 64'(rr_out), 64'h0);
    rst_ni = 1'b0;
    #1;
    check("ux_clr", 64'(rr_unexp), 64'h0);
    rst_ni = 1'b1;
    step();

    // Reset while a transfer is in flight discards it
    drive(3'b001, 1'b1, 1'b0, 1'b0, 32'h0);
    step();
    check("mr_out1", 64'(rr_out), 64'h1);
    do_reset();
    drive(3'b000, 1'b0, 1'b1, 1'b0, 32'h99);
    check("mr_rv", 64'(rr_rv), 64'h0);
    step();
    drive(3'b000, 1'b0, 1'b0, 1'b0, 32'h0);
    check("mr_unexp", 64'(rr_unexp), 64'h1);
    check("mr_fp_unexp", 64'(fp_unexp), 64'h1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
